// File: rtl/load_store_unit_if.sv
// load_store_unit_if: CPU request/response and data-memory signals of the load/store unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic        mem_write_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_write_enable, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_write_enable, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V byte/half/word load-store with read-modify-write sub-word stores; MISALIGN_FAULT_EN makes misaligned H/W accesses fault instead of force-aligning
module load_store_unit (
    input logic             clk,
    input logic             reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        fault_q;
    logic        legal;
    logic        req_fault;
    logic [31:0] req_addr_al;
    logic        accept;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign accept = (state == IDLE) && bus.req_valid;

    assign legal = bus.req_write ? (!bus.req_funct3[2] && bus.req_funct3[1:0] != 2'b11)
                                 : (bus.req_funct3[1:0] != 2'b11 && !(bus.req_funct3[2] && bus.req_funct3[1]));

`ifdef MISALIGN_FAULT_EN
    assign req_fault   = !legal || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
                                || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
    assign req_addr_al = bus.req_addr;
`else
    assign req_fault   = !legal;
    assign req_addr_al = (bus.req_funct3[1:0] == 2'b01) ? {bus.req_addr[31:1], 1'b0} :
                         (bus.req_funct3[1:0] == 2'b10) ? {bus.req_addr[31:2], 2'b00} : bus.req_addr;
`endif

    assign ld_byte   = word_q[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half   = word_q[{addr_q[1], 4'b0000} +: 16];
    assign load_data = (funct3_q[1:0] == 2'b00) ? {{24{!funct3_q[2] && ld_byte[7]}}, ld_byte} :
                       (funct3_q[1:0] == 2'b01) ? {{16{!funct3_q[2] && ld_half[15]}}, ld_half} : word_q;
    assign lane_mask = ((funct3_q[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << {addr_q[1:0], 3'b000};
    assign merged    = (word_q & ~lane_mask) | ((wdata_q << {addr_q[1:0], 3'b000}) & lane_mask);

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nxt;
    end

    // next-state: faults skip memory, SW skips the read, SB/SH read then write
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = !bus.req_valid ? IDLE :
                                 req_fault ? RESP :
                                 (bus.req_write && bus.req_funct3[1:0] == 2'b10) ? WR : RD;
            RD:      state_nxt = write_q ? WR : RESP;
            WR:      state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // request latch at accept and old-word capture at the end of RD
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            fault_q  <= 1'b0;
            word_q   <= 32'h0;
        end else begin
            if (accept) begin
                write_q  <= bus.req_write;
                funct3_q <= bus.req_funct3;
                addr_q   <= req_addr_al;
                wdata_q  <= bus.req_wdata;
                fault_q  <= req_fault;
            end
            if (state == RD) word_q <= bus.mem_rdata;
        end
    end

    // outputs decoded from state; memory write is suppressed while reset is high
    always_comb begin
        bus.req_ready        = (state == IDLE);
        bus.resp_valid       = (state == RESP);
        bus.resp_fault       = (state == RESP) && fault_q;
        bus.resp_rdata       = (state == RESP && !write_q && !fault_q) ? load_data : 32'h0;
        bus.mem_addr         = (state == RD || state == WR) ? {addr_q[31:2], 2'b00} : 32'h0;
        bus.mem_write_enable = (state == WR) && !reset;
        bus.mem_wdata        = (state != WR) ? 32'h0 : (funct3_q[1:0] == 2'b10) ? wdata_q : merged;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a byte-array reference model
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        int          lat;
        logic        fault;
        logic [31:0] rdata;
        int          writes;
    } exp_t;

    logic [31:0] tbmem [16];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_idx;
    logic [31:0] pre_data;
    int          wr_count = 0;
    logic [7:0]  mbytes [64];
    int          n_checks = 0;
    int          n_fail = 0;

    assign bus.mem_rdata = tbmem[bus.mem_addr[5:2]];

    // environment data memory with a backdoor preload port
    always @(posedge clk) begin
        if (pre_we) tbmem[pre_idx] <= pre_data;
        else if (bus.mem_write_enable) begin
            tbmem[bus.mem_addr[5:2]] <= bus.mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    function automatic exp_t model(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic legal;
        int sz;
        int ea;
        logic [31:0] v;
        e = '0;
        legal = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
        sz = legal ? (1 << f[1:0]) : 1;
        ea = int'(a);
`ifdef MISALIGN_FAULT_EN
        if (legal && (ea % sz) != 0) legal = 1'b0;
`else
        ea = ea - (ea % sz);
`endif
        if (!legal) begin
            e.lat = 1;
            e.fault = 1'b1;
        end else if (w) begin
            for (int i = 0; i < sz; i++) mbytes[ea + i] = d[8*i +: 8];
            e.lat = (sz == 4) ? 2 : 3;
            e.writes = 1;
        end else begin
            v = '0;
            for (int i = 0; i < sz; i++) v = v | (32'(mbytes[ea + i]) << (8 * i));
            if (!f[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
            e.lat = 2;
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic preload(input int idx, input logic [31:0] v);
        pre_we = 1'b1;
        pre_idx = idx[3:0];
        pre_data = v;
        @(posedge clk);
        #1 pre_we = 1'b0;
        for (int b = 0; b < 4; b++) mbytes[4*idx + b] = v[8*b +: 8];
    endtask

    task automatic run_req(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic fault, output logic [31:0] rdata,
                           output int writes, output int busy);
        int w0;
        int k;
        lat = -1;
        fault = 1'b0;
        rdata = '0;
        writes = 0;
        busy = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_funct3 = f;
        bus.req_addr = a;
        bus.req_wdata = d;
        k = 0;
        while (!bus.req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        w0 = wr_count;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.req_ready) busy++;
            if (bus.resp_valid) begin
                lat = i;
                fault = bus.resp_fault;
                rdata = bus.resp_rdata;
                break;
            end
        end
        writes = wr_count - w0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
        n_checks++; if (bus.resp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_resp_fault got %b want 0", bus.resp_fault); end
        n_checks++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h want 0", bus.resp_rdata); end
        n_checks++; if (bus.mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", bus.mem_write_enable); end
        n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
    endtask

    task automatic test_loads_stores;
        int lat, writes, busy;
        logic fault;
        logic [31:0] rd;
        exp_t e;
        preload(0, 32'hDEADBEEF);
        preload(1, 32'h11223344);
        e = model(1'b1, 3'b000, 32'h5, 32'hFFFFFFAB);
        run_req(1'b1, 3'b000, 32'h5, 32'hFFFFFFAB, lat, fault, rd, writes, busy);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency got %0d want 3", lat); end
        n_checks++; if (writes !== 1) begin n_fail++; $display("FAIL sb_write_pulses got %0d want 1", writes); end
        n_checks++; if (rd !== 32'h0 || fault !== 1'b0) begin n_fail++; $display("FAIL sb_resp got rdata %h fault %b want 0 0", rd, fault); end
        n_checks++; if (tbmem[1] !== 32'h1122AB44) begin n_fail++; $display("FAIL sb_word1 got %h want 1122ab44", tbmem[1]); end
        @(negedge clk);
        n_checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL resp_one_cycle got valid %b ready %b want 0 1", bus.resp_valid, bus.req_ready); end
        e = model(1'b0, 3'b000, 32'h5, 32'h0);
        run_req(1'b0, 3'b000, 32'h5, 32'h0, lat, fault, rd, writes, busy);
        n_checks++; if (rd !== 32'hFFFFFFAB || lat !== 2) begin n_fail++; $display("FAIL lb got %h lat %0d want ffffffab lat 2", rd, lat); end
        e = model(1'b0, 3'b100, 32'h5, 32'h0);
        run_req(1'b0, 3'b100, 32'h5, 32'h0, lat, fault, rd, writes, busy);
        n_checks++; if (rd !== 32'h000000AB) begin n_fail++; $display("FAIL lbu got %h want 000000ab", rd); end
        e = model(1'b0, 3'b001, 32'h6, 32'h0);
        run_req(1'b0, 3'b001, 32'h6, 32'h0, lat, fault, rd, writes, busy);
        n_checks++; if (rd !== 32'h00001122) begin n_fail++; $display("FAIL lh_6 got %h want 00001122", rd); end
        e = model(1'b1, 3'b001, 32'h6, 32'h00008001);
        run_req(1'b1, 3'b001, 32'h6, 32'h00008001, lat, fault, rd, writes, busy);
        n_checks++; if (tbmem[1] !== 32'h8001AB44 || lat !== 3) begin n_fail++; $display("FAIL sh_word1 got %h lat %0d want 8001ab44 lat 3", tbmem[1], lat); end
        e = model(1'b0, 3'b001, 32'h6, 32'h0);
        run_req(1'b0, 3'b001, 32'h6, 32'h0, lat, fault, rd, writes, busy);
        n_checks++; if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_after_sh got %h want ffff8001", rd); end
        e = model(1'b1, 3'b010, 32'h8, 32'hA5A55A5A);
        run_req(1'b1, 3'b010, 32'h8, 32'hA5A55A5A, lat, fault, rd, writes, busy);
        n_checks++; if (tbmem[2] !== 32'hA5A55A5A || lat !== 2 || writes !== 1) begin n_fail++; $display("FAIL sw got %h lat %0d writes %0d want a5a55a5a lat 2 writes 1", tbmem[2], lat, writes); end
        e = model(1'b0, 3'b010, 32'h2, 32'h0);
        run_req(1'b0, 3'b010, 32'h2, 32'h0, lat, fault, rd, writes, busy);
`ifdef MISALIGN_FAULT_EN
        n_checks++; if (fault !== 1'b1 || rd !== 32'h0 || writes !== 0 || lat !== 1) begin n_fail++; $display("FAIL lw_misaligned got fault %b rdata %h writes %0d lat %0d want 1 0 0 1", fault, rd, writes, lat); end
`else
        n_checks++; if (fault !== 1'b0 || rd !== 32'hDEADBEEF || lat !== 2) begin n_fail++; $display("FAIL lw_misaligned got fault %b rdata %h lat %0d want 0 deadbeef 2", fault, rd, lat); end
`endif
    endtask

    task automatic test_fault;
        int lat, writes, busy;
        logic fault;
        logic [31:0] rd;
        exp_t e;
        e = model(1'b0, 3'b111, 32'h4, 32'h0);
        run_req(1'b0, 3'b111, 32'h4, 32'h0, lat, fault, rd, writes, busy);
        n_checks++; if (fault !== 1'b1 || lat !== 1 || rd !== 32'h0) begin n_fail++; $display("FAIL load_f111 got fault %b lat %0d rdata %h want 1 1 0", fault, lat, rd); end
        e = model(1'b1, 3'b100, 32'h4, 32'h12345678);
        run_req(1'b1, 3'b100, 32'h4, 32'h12345678, lat, fault, rd, writes, busy);
        n_checks++; if (fault !== 1'b1 || lat !== 1 || writes !== 0) begin n_fail++; $display("FAIL store_f100 got fault %b lat %0d writes %0d want 1 1 0", fault, lat, writes); end
    endtask

    task automatic test_reset_mid_op;
        int w0;
        int seen;
        preload(3, 32'hCAFEF00D);
        w0 = wr_count;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr = 32'hD;
        bus.req_wdata = 32'h55;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++; if (bus.mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_in_wr_we got %b want 0", bus.mem_write_enable); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_wr_ready got %b want 1", bus.req_ready); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.resp_valid) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL reset_in_wr_resp got %0d responses want 0", seen); end
        n_checks++; if (tbmem[3] !== 32'hCAFEF00D || wr_count !== w0) begin n_fail++; $display("FAIL reset_in_wr_mem got %h writes %0d want cafef00d 0", tbmem[3], wr_count - w0); end
    endtask

    task automatic test_back_to_back;
        int lat, writes, busy;
        logic fault;
        logic [31:0] rd;
        logic w;
        logic [2:0] f;
        logic [31:0] a, d;
        exp_t e;
        for (int n = 0; n < 200; n++) begin
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 63));
            d = $urandom;
            e = model(w, f, a, d);
            run_req(w, f, a, d, lat, fault, rd, writes, busy);
            n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL rand_latency n=%0d w=%b f=%0d a=%h got %0d want %0d", n, w, f, a, lat, e.lat); end
            n_checks++; if (fault !== e.fault) begin n_fail++; $display("FAIL rand_fault n=%0d w=%b f=%0d a=%h got %b want %b", n, w, f, a, fault, e.fault); end
            n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL rand_rdata n=%0d w=%b f=%0d a=%h got %h want %h", n, w, f, a, rd, e.rdata); end
            n_checks++; if (writes !== e.writes) begin n_fail++; $display("FAIL rand_writes n=%0d w=%b f=%0d a=%h got %0d want %0d", n, w, f, a, writes, e.writes); end
            n_checks++; if (busy !== 0) begin n_fail++; $display("FAIL rand_ready_busy n=%0d got %0d ready cycles want 0", n, busy); end
        end
    endtask

    task automatic test_memory_image;
        logic [31:0] want;
        for (int i = 0; i < 16; i++) begin
            want = {mbytes[4*i+3], mbytes[4*i+2], mbytes[4*i+1], mbytes[4*i]};
            n_checks++; if (tbmem[i] !== want) begin n_fail++; $display("FAIL mem_image word %0d got %h want %h", i, tbmem[i], want); end
        end
    endtask

    initial begin
        test_reset;
        test_loads_stores;
        test_fault;
        test_reset_mid_op;
        test_back_to_back;
        test_memory_image;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port req_valid, input, 1 bit: CPU request present.
REQ-004 SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-005 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_funct3, input, 3 bits: RISC-V size code. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
REQ-007 SHALL have port req_addr, input, 32 bits: byte address (rs1 + offset).
REQ-008 SHALL have port req_wdata, input, 32 bits: store data (rs2).
REQ-009 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32 bits: extended load result.
REQ-011 SHALL have port resp_fault, output, 1 bit: access rejected; qualified by resp_valid.
REQ-012 SHALL have port mem_addr, output, 32 bits: word-aligned byte address to data memory.
REQ-013 SHALL have port mem_write_enable, output, 1 bit: word write strobe to data memory.
REQ-014 SHALL have port mem_wdata, output, 32 bits: full word to write.
REQ-015 SHALL have port mem_rdata, input, 32 bits: word read combinationally from mem_addr.

Function
REQ-016 SHALL use the FSM states IDLE, RD, WR and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge when the state is IDLE and req_valid=1, and SHALL latch write, funct3, addr and wdata at that edge.
REQ-018 SHALL treat a load (IDLE->RD->RESP) as follows: resp_valid 2 cycles after the accept edge; resp_rdata captured from mem_rdata at the end of RD.
REQ-019 SHALL treat SW as IDLE->WR->RESP: mem_wdata = latched wdata; resp_valid 2 cycles after accept.
REQ-020 SHALL treat SB/SH as a read-modify-write (IDLE->RD->WR->RESP): capture the old word in RD; in WR, replace only byte lane addr[1:0] (SB) or halfword lane addr[1] (SH) with wdata[7:0]/[15:0]; resp_valid 3 cycles after accept.
REQ-021 SHALL drive mem_addr to {latched addr[31:2],2'b00} in RD/WR and to 0 in IDLE/RESP.
REQ-022 SHALL assert mem_write_enable only in WR, gated with !reset.
REQ-023 SHALL extract loads from lane addr[1:0]: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW is the word unmodified.
REQ-024 SHALL hold RESP for exactly one cycle (resp_valid=1) before returning to IDLE; there is no response backpressure.
REQ-025 SHALL drive resp_rdata as 0 for stores and for faulted accesses.
REQ-026 SHALL treat an illegal funct3 as follows: loads 011/110/111; stores with any code other than 000/001/010. Such a request SHALL go IDLE->RESP with resp_fault=1, no memory access, and resp_valid 1 cycle after accept.
REQ-027 SHALL ignore req_valid while req_ready=0; the requester holds the request until accepted.

Reset
REQ-028 SHALL, with reset=1 at a rising edge, force state to IDLE. It SHALL clear resp_valid, resp_fault and resp_rdata to 0 and clear all latched request fields.
REQ-029 SHALL, on reset mid-operation, abandon the operation with no response. A reset coinciding with WR SHALL NOT write memory (per REQ-022).
REQ-030 SHALL drive outputs after reset as follows: req_ready=1, mem_write_enable=0, mem_addr=0, mem_wdata=0.

Configuration
REQ-031 SHALL, with macro MISALIGN_FAULT_EN defined, treat an H/HU access with addr[0]=1 or a W access with addr[1:0]!=0 as a fault, handled per REQ-026 timing.
REQ-032 SHALL, without MISALIGN_FAULT_EN, force-align misaligned accesses by clearing addr[0] (H) or addr[1:0] (W) at latch time and complete them normally.

Verification
REQ-033 SHALL be verified by: preload word1=0x11223344; SB addr 0x5 wdata 0xFFFFFFAB -> one mem_write_enable pulse, word1=0x1122AB44, resp_valid 3 cycles after accept.
REQ-034 SHALL be verified by: after REQ-033, LB addr 0x5 -> resp_rdata=0xFFFFFFAB; LBU -> 0x000000AB; LH addr 0x6 -> 0x00001122.
REQ-035 SHALL be verified by: SH addr 0x6 wdata 0x8001 onto 0x1122AB44 -> 0x8001AB44; LH addr 0x6 -> 0xFFFF8001.
REQ-036 SHALL be verified by: LW addr 0x2 with word0=0xDEADBEEF -> with MISALIGN_FAULT_EN: resp_fault=1, rdata=0, no write; without it: rdata=0xDEADBEEF.
REQ-037 SHALL be verified by: load with funct3=111 -> resp_fault=1 one cycle after accept; then reset asserted during the WR of an SB -> memory unchanged, no resp_valid, req_ready=1 on the next cycle.
